// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer, stability-count debouncer and press/release pulse generator.
// Each channel runs its own FSM; a new level is accepted after N_STABLE consecutive agreeing samples.
module btn_debounce #(
  parameter int NB_BTN   = 4,
  parameter int N_STABLE = 1000000,
  parameter int NB_CNT   = $clog2(N_STABLE + 1)
) (
  input  logic              clock,
  input  logic              ck_rst,
  input  logic [NB_BTN-1:0] i_btn_raw,
  output logic [NB_BTN-1:0] o_btn,
  output logic [NB_BTN-1:0] o_btn_press,
  output logic [NB_BTN-1:0] o_btn_release
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_STABLE - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  logic [NB_BTN-1:0] sync_p0;
  logic [NB_BTN-1:0] sync_p1;
  state_t            state [NB_BTN];
  logic [NB_CNT-1:0] cnt   [NB_BTN];

  // Stage p0/p1: metastability synchronizer; only sync_p1 feeds the FSMs
  always_ff @(posedge clock) begin
    if (ck_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= i_btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-channel debounce FSM; cnt tracks consecutive disagreeing samples
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB_BTN; i++) begin
      if (ck_rst) begin
        state[i]         <= RELEASED;
        cnt[i]           <= '0;
        o_btn[i]         <= 1'b0;
        o_btn_press[i]   <= 1'b0;
        o_btn_release[i] <= 1'b0;
      end else begin
        o_btn_press[i]   <= 1'b0;
        o_btn_release[i] <= 1'b0;
        case (state[i])
          RELEASED: begin
            if (sync_p1[i]) begin
              state[i] <= PRESS_CHK;
              cnt[i]   <= CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (!sync_p1[i]) begin
              state[i] <= RELEASED;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]       <= PRESSED;
              cnt[i]         <= '0;
              o_btn[i]       <= 1'b1;
              o_btn_press[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!sync_p1[i]) begin
              state[i] <= RELEASE_CHK;
              cnt[i]   <= CNT_ONE;
            end
          end
          RELEASE_CHK: begin
            if (sync_p1[i]) begin
              state[i] <= PRESSED;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]         <= RELEASED;
              cnt[i]           <= '0;
              o_btn[i]         <= 1'b0;
              o_btn_release[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i] <= RELEASED;
            cnt[i]   <= '0;
            o_btn[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
